// File: rtl/flag_eval_engine_pkg.sv
// rtl/flag_eval_engine_pkg.sv - shared mode codes, FSM states and default addresses for flag_eval_engine
//
// Purpose : common definitions for the flag evaluator and its match helper.
// Contents: mode codes, FSM state encoding, default source/destination base addresses.
package flag_eval_engine_pkg;

  // Run-time match mode; code 3 is not a distinct mode and evaluates as EQ.
  typedef logic [1:0] fe_mode_t;
  localparam fe_mode_t FE_MODE_EQ      = 2'd0;
  localparam fe_mode_t FE_MODE_NONZERO = 2'd1;
  localparam fe_mode_t FE_MODE_MASK    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } fe_state_e;

  localparam logic [15:0] FE_DEF_SRC_BASE = 16'h0000;
  localparam logic [15:0] FE_DEF_DST_BASE = 16'h0002;

endpackage

// File: rtl/flag_eval_engine_if.sv
// rtl/flag_eval_engine_if.sv - shared data memory port used by the flag evaluator
//
// Purpose : groups the memory address/write/read signals.
// Signals : address, wr_en, data_out (engine -> memory); data_in (memory -> engine).
// Modports: master = engine side, slave = memory side.
interface flag_eval_engine_if #(
  parameter int WORD_WIDTH = 16
);
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic [WORD_WIDTH-1:0] data_in;

  modport master (output address, output wr_en, output data_out, input data_in);
  modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface

// File: rtl/flag_eval_engine_flag_match.sv
// rtl/flag_eval_engine_flag_match.sv - combinational single-word flag test
//
// Purpose : decides whether one memory word counts as a set flag.
// Ports   : data_in (word under test), mode (match mode) -> match.
module flag_match
  import flag_eval_engine_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 16,
  parameter logic [WORD_WIDTH-1:0] MATCH_VALUE = 16'h0001
) (
  input  logic [WORD_WIDTH-1:0] data_in,
  input  fe_mode_t              mode,
  output logic                  match
);

  always_comb begin
    match = 1'b0;
    case (mode)
      FE_MODE_NONZERO: match = (data_in != '0);
      FE_MODE_MASK:    match = ((data_in & MATCH_VALUE) != '0);
      default:         match = (data_in == MATCH_VALUE);
    endcase
  end

endmodule

// File: rtl/flag_eval_engine.sv
// rtl/flag_eval_engine.sv - reads NUM_FLAGS words, tests each, writes per-channel result flags back
//
// Purpose : on start, reads consecutive words from SRC_BASE, evaluates each with flag_match,
//           then writes one result word per channel to DST_BASE.. and raises done.
// Ports   : clock, rst (async, active high), start, mode (latched at start),
//           mem (memory bus, master), flags_out, any_set, busy, done. All outputs registered.
module flag_eval_engine
  import flag_eval_engine_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    NUM_FLAGS   = 4,
  parameter logic [WORD_WIDTH-1:0] SRC_BASE    = FE_DEF_SRC_BASE,
  parameter logic [WORD_WIDTH-1:0] DST_BASE    = FE_DEF_DST_BASE,
  parameter int                    RD_LATENCY  = 1,
  parameter logic [WORD_WIDTH-1:0] MATCH_VALUE = 16'h0001,
  parameter bit                    WRITE_ALL   = 1'b0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  fe_mode_t              mode,
  flag_eval_engine_if.master    mem,
  output logic [NUM_FLAGS-1:0]  flags_out,
  output logic                  any_set,
  output logic                  busy,
  output logic                  done
);

  localparam int IDXW = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1;
  localparam logic [IDXW-1:0]       IDX_LAST   = IDXW'(NUM_FLAGS - 1);
  localparam logic [1:0]            CNT_RELOAD = 2'(RD_LATENCY - 1);
  localparam logic [WORD_WIDTH-1:0] ONE        = WORD_WIDTH'(1);

  fe_state_e             state_q, state_n;
  logic [IDXW-1:0]       idx_q, idx_n;
  logic [1:0]            cnt_q, cnt_n;
  fe_mode_t              mode_q, mode_n;
  logic [NUM_FLAGS-1:0]  flags_q, flags_n;
  logic [WORD_WIDTH-1:0] addr_q, addr_n;
  logic [WORD_WIDTH-1:0] dout_q, dout_n;
  logic                  wr_q, wr_n;
  logic                  any_n, busy_n, done_n;
  logic                  match;

  flag_match #(
    .WORD_WIDTH  (WORD_WIDTH),
    .MATCH_VALUE (MATCH_VALUE)
  ) u_match (
    .data_in (mem.data_in),
    .mode    (mode_q),
    .match   (match)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= FE_MODE_EQ;
      flags_q   <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      wr_q      <= 1'b0;
      any_set   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      mode_q    <= mode_n;
      flags_q   <= flags_n;
      addr_q    <= addr_n;
      dout_q    <= dout_n;
      wr_q      <= wr_n;
      any_set   <= any_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    mode_n  = mode_q;
    flags_n = flags_q;
    addr_n  = addr_q;
    dout_n  = dout_q;
    wr_n    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_READ;
          mode_n  = mode;
          flags_n = '0;
          idx_n   = '0;
          addr_n  = SRC_BASE;
          cnt_n   = CNT_RELOAD;
        end
      end
      ST_READ: begin
        if (cnt_q != 2'd0) begin
          cnt_n = cnt_q - 2'd1;
        end else begin
          flags_n[idx_q] = match;
          if (idx_q != IDX_LAST) begin
            idx_n  = idx_q + IDXW'(1);
            addr_n = SRC_BASE + WORD_WIDTH'(idx_q) + ONE;
            cnt_n  = CNT_RELOAD;
          end else begin
            // flags_n[0] already holds the just-sampled bit when NUM_FLAGS == 1
            state_n = ST_WRITE;
            idx_n   = '0;
            addr_n  = DST_BASE;
            dout_n  = {{(WORD_WIDTH-1){1'b0}}, flags_n[0]};
            wr_n    = WRITE_ALL | flags_n[0];
          end
        end
      end
      ST_WRITE: begin
        if (idx_q != IDX_LAST) begin
          idx_n  = idx_q + IDXW'(1);
          addr_n = DST_BASE + WORD_WIDTH'(idx_q) + ONE;
          dout_n = {{(WORD_WIDTH-1){1'b0}}, flags_q[idx_n]};
          wr_n   = WRITE_ALL | flags_q[idx_n];
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        // Start must drop before another run, so a held start cannot retrigger.
        if (!start) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    any_n  = |flags_n;
    busy_n = (state_n == ST_READ) || (state_n == ST_WRITE);
    done_n = (state_n == ST_DONE);
  end

  assign flags_out    = flags_q;
  assign mem.address  = addr_q;
  assign mem.data_out = dout_q;
  assign mem.wr_en    = wr_q;

endmodule

// File: tb/tb_flag_eval_engine.sv
// tb/tb_flag_eval_engine.sv - directed-vector bench for flag_eval_engine
module tb_flag_eval_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a   [4];
  logic       start_a [4];
  logic [1:0] mode_a  [4];

  logic [15:0] addr_a  [4];
  logic [15:0] dout_a  [4];
  logic        wr_a    [4];
  logic [3:0]  flags_a [4];
  logic        any_a   [4];
  logic        busy_a  [4];
  logic        done_a  [4];

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] mem2 [16];
  logic [15:0] mem3 [16];
  logic [15:0] d2a, d2b;

  flag_eval_engine_if #(.WORD_WIDTH(16)) bus0 ();
  flag_eval_engine_if #(.WORD_WIDTH(16)) bus1 ();
  flag_eval_engine_if #(.WORD_WIDTH(16)) bus2 ();
  flag_eval_engine_if #(.WORD_WIDTH(16)) bus3 ();

  // Memory models: 16-entry, index by low address bits (covers FFFE..0001 wrap for u3).
  assign bus0.data_in = mem0[bus0.address[3:0]];
  assign bus1.data_in = mem1[bus1.address[3:0]];
  assign bus3.data_in = mem3[bus3.address[3:0]];
  // Three-edge read latency: two register stages after the address register.
  always @(posedge clock) begin
    d2a <= mem2[bus2.address[3:0]];
    d2b <= d2a;
  end
  assign bus2.data_in = d2b;

  flag_eval_engine u0 (
    .clock(clock), .rst(rst_a[0]), .start(start_a[0]), .mode(mode_a[0]), .mem(bus0),
    .flags_out(flags_a[0]), .any_set(any_a[0]), .busy(busy_a[0]), .done(done_a[0]));
  flag_eval_engine #(.WRITE_ALL(1'b1)) u1 (
    .clock(clock), .rst(rst_a[1]), .start(start_a[1]), .mode(mode_a[1]), .mem(bus1),
    .flags_out(flags_a[1]), .any_set(any_a[1]), .busy(busy_a[1]), .done(done_a[1]));
  flag_eval_engine #(.RD_LATENCY(3)) u2 (
    .clock(clock), .rst(rst_a[2]), .start(start_a[2]), .mode(mode_a[2]), .mem(bus2),
    .flags_out(flags_a[2]), .any_set(any_a[2]), .busy(busy_a[2]), .done(done_a[2]));
  flag_eval_engine #(.MATCH_VALUE(16'h0080), .SRC_BASE(16'hFFFE)) u3 (
    .clock(clock), .rst(rst_a[3]), .start(start_a[3]), .mode(mode_a[3]), .mem(bus3),
    .flags_out(flags_a[3]), .any_set(any_a[3]), .busy(busy_a[3]), .done(done_a[3]));

  assign addr_a[0] = bus0.address;  assign dout_a[0] = bus0.data_out;  assign wr_a[0] = bus0.wr_en;
  assign addr_a[1] = bus1.address;  assign dout_a[1] = bus1.data_out;  assign wr_a[1] = bus1.wr_en;
  assign addr_a[2] = bus2.address;  assign dout_a[2] = bus2.data_out;  assign wr_a[2] = bus2.wr_en;
  assign addr_a[3] = bus3.address;  assign dout_a[3] = bus3.data_out;  assign wr_a[3] = bus3.wr_en;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] addr_tr [64];
  logic [3:0]  flag_tr [64];
  logic [15:0] obs_wa  [16];
  logic [15:0] obs_wd  [16];
  int          nw;
  int          done_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Raise start and follow the run edge by edge until done or the budget expires.
  // Trace index n is the number of edges after the start edge E0.
  task automatic run(input int k, input int budget);
    int n;
    bit finished;
    nw = 0;
    n = 0;
    finished = 0;
    @(negedge clock);
    start_a[k] = 1'b1;
    while (!finished && n < budget) begin
      @(posedge clock);
      #1;
      addr_tr[n] = addr_a[k];
      flag_tr[n] = flags_a[k];
      if (wr_a[k] && nw < 16) begin
        obs_wa[nw] = addr_a[k];
        obs_wd[nw] = dout_a[k];
        nw++;
      end
      if (done_a[k]) finished = 1;
      else n++;
    end
    done_at = finished ? n : -1;
  endtask

  task automatic drop_start(input int k);
    @(negedge clock);
    start_a[k] = 1'b0;
    @(posedge clock);
    #1;
    check("idle_done_low", {31'd0, done_a[k]}, 32'd0);
  endtask

  initial begin
    int n;
    bit hit;
    int extra_wr;

    for (int k = 0; k < 4; k++) begin
      rst_a[k] = 1'b1;
      start_a[k] = 1'b0;
      mode_a[k] = 2'd0;
    end
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 16'h0; mem1[i] = 16'h0; mem2[i] = 16'h0; mem3[i] = 16'h0;
    end
    repeat (2) @(posedge clock);
    #1;
    check("rst_addr",  {16'd0, addr_a[0]}, 32'd0);
    check("rst_wr",    {31'd0, wr_a[0]},   32'd0);
    check("rst_flags", {28'd0, flags_a[0]}, 32'd0);
    check("rst_busy",  {31'd0, busy_a[0]}, 32'd0);
    check("rst_done",  {31'd0, done_a[0]}, 32'd0);
    @(negedge clock);
    for (int k = 0; k < 4; k++) rst_a[k] = 1'b0;

    // 1: defaults, EQ against 1
    mem0[0] = 16'h1; mem0[1] = 16'h0; mem0[2] = 16'h1; mem0[3] = 16'h5;
    mode_a[0] = 2'd0;
    run(0, 40);
    check("t1_done_at", 32'(done_at), 32'd8);
    check("t1_flags",   {28'd0, flags_a[0]}, 32'h5);
    check("t1_any",     {31'd0, any_a[0]}, 32'd1);
    check("t1_nwrites", 32'(nw), 32'd2);
    check("t1_w0_addr", {16'd0, obs_wa[0]}, 32'h2);
    check("t1_w0_data", {16'd0, obs_wd[0]}, 32'h1);
    check("t1_w1_addr", {16'd0, obs_wa[1]}, 32'h4);
    check("t1_w1_data", {16'd0, obs_wd[1]}, 32'h1);
    check("t1_busy_done", {31'd0, busy_a[0]}, 32'd0);
    drop_start(0);

    // mode code 3 evaluates as EQ
    mode_a[0] = 2'd3;
    run(0, 40);
    check("m3_flags", {28'd0, flags_a[0]}, 32'h5);
    drop_start(0);

    // 2: WRITE_ALL, NONZERO
    mem1[0] = 16'h0; mem1[1] = 16'h7; mem1[2] = 16'h0; mem1[3] = 16'hFFFF;
    mode_a[1] = 2'd1;
    run(1, 40);
    check("t2_done_at", 32'(done_at), 32'd8);
    check("t2_flags",   {28'd0, flags_a[1]}, 32'hA);
    check("t2_any",     {31'd0, any_a[1]}, 32'd1);
    check("t2_nwrites", 32'(nw), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_w%0d_addr", i), {16'd0, obs_wa[i]}, 32'(2 + i));
      check($sformatf("t2_w%0d_data", i), {16'd0, obs_wd[i]}, 32'(i % 2));
    end
    drop_start(1);

    // 3: three-edge read latency
    for (int i = 0; i < 4; i++) mem2[i] = 16'h1;
    mode_a[2] = 2'd0;
    run(2, 60);
    check("t3_done_at", 32'(done_at), 32'd16);
    check("t3_flags",   {28'd0, flags_a[2]}, 32'hF);
    check("t3_addr_e0", {16'd0, addr_tr[0]}, 32'h0);
    check("t3_addr_e2", {16'd0, addr_tr[2]}, 32'h0);
    check("t3_addr_e3", {16'd0, addr_tr[3]}, 32'h1);
    check("t3_addr_e5", {16'd0, addr_tr[5]}, 32'h1);
    check("t3_addr_e6", {16'd0, addr_tr[6]}, 32'h2);
    check("t3_nwrites", 32'(nw), 32'd4);
    drop_start(2);

    // 4: MASK with address wrap FFFE, FFFF, 0000, 0001
    mem3[14] = 16'h0080; mem3[15] = 16'h007F; mem3[0] = 16'h00FF; mem3[1] = 16'h0000;
    mode_a[3] = 2'd2;
    run(3, 40);
    check("t4_addr_e0", {16'd0, addr_tr[0]}, 32'hFFFE);
    check("t4_addr_e1", {16'd0, addr_tr[1]}, 32'hFFFF);
    check("t4_addr_e2", {16'd0, addr_tr[2]}, 32'h0000);
    check("t4_flags",   {28'd0, flags_a[3]}, 32'h5);
    check("t4_done_at", 32'(done_at), 32'd8);
    drop_start(3);

    // 5: async reset during WRITE after the first strobe
    mode_a[0] = 2'd0;
    @(negedge clock);
    start_a[0] = 1'b1;
    n = 0;
    hit = 0;
    while (!hit && n < 20) begin
      @(posedge clock);
      #1;
      if (wr_a[0]) hit = 1;
      n++;
    end
    check("t5_first_strobe", {31'd0, hit}, 32'd1);
    check("t5_strobe_addr", {16'd0, addr_a[0]}, 32'h2);
    start_a[0] = 1'b0;
    #2 rst_a[0] = 1'b1;
    #1;
    check("t5_rst_wr",    {31'd0, wr_a[0]},   32'd0);
    check("t5_rst_addr",  {16'd0, addr_a[0]}, 32'd0);
    check("t5_rst_dout",  {16'd0, dout_a[0]}, 32'd0);
    check("t5_rst_flags", {28'd0, flags_a[0]}, 32'd0);
    check("t5_rst_any",   {31'd0, any_a[0]},  32'd0);
    check("t5_rst_busy",  {31'd0, busy_a[0]}, 32'd0);
    extra_wr = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (wr_a[0]) extra_wr++;
    end
    @(negedge clock);
    rst_a[0] = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (wr_a[0]) extra_wr++;
    end
    check("t5_no_more_strobes", 32'(extra_wr), 32'd0);
    run(0, 40);
    check("t5_rerun_done_at", 32'(done_at), 32'd8);
    check("t5_rerun_flags",   {28'd0, flags_a[0]}, 32'h5);
    check("t5_rerun_nwrites", 32'(nw), 32'd2);

    // 6: start held after done -> no retrigger
    extra_wr = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (wr_a[0] || busy_a[0]) extra_wr++;
    end
    check("t6_held_done", {31'd0, done_a[0]}, 32'd1);
    check("t6_no_retrigger", 32'(extra_wr), 32'd0);
    check("t6_flags_hold", {28'd0, flags_a[0]}, 32'h5);
    drop_start(0);
    check("t6_flags_hold_idle", {28'd0, flags_a[0]}, 32'h5);
    mem0[0] = 16'h0; mem0[1] = 16'h5; mem0[2] = 16'h0; mem0[3] = 16'h1;
    mode_a[0] = 2'd1;
    run(0, 40);
    check("t6_flags_cleared_e0", {28'd0, flag_tr[0]}, 32'h0);
    check("t6_new_flags", {28'd0, flags_a[0]}, 32'hA);
    check("t6_new_done_at", 32'(done_at), 32'd8);
    check("t6_new_nwrites", 32'(nw), 32'd2);
    check("t6_new_w0_addr", {16'd0, obs_wa[0]}, 32'h3);
    check("t6_new_w1_addr", {16'd0, obs_wa[1]}, 32'h5);
    drop_start(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
